// File: rtl/bus_sequencer.sv
// Subcycle sequencer for a 4-bit multiplexed external bus: address nibbles, opcode capture, ROM/RAM strobes.
// Optional X3 stall hold is compiled in when BUS_STALL_EN is defined; otherwise the stall port is ignored.
module bus_sequencer #(
    parameter int ADDR_NIBBLES = 3,
    parameter int ROM_BANKS    = 1,
    parameter int RAM_BANKS    = 4,
    parameter int CYC_W        = 4,
    localparam int PC_W      = 4 * ADDR_NIBBLES,
    localparam int ROM_SEL_W = (ROM_BANKS > 1) ? $clog2(ROM_BANKS) : 1,
    localparam int RAM_SEL_W = (RAM_BANKS > 1) ? $clog2(RAM_BANKS) : 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [PC_W-1:0]      pc,
    input  logic [3:0]           regval,
    input  logic                 reg_out_enable,
    input  logic [3:0]           data_in,
    output logic [3:0]           data_out,
    output logic                 data_oe,
    input  logic [ROM_SEL_W-1:0] rom_bank_sel,
    input  logic                 bank_write,
    input  logic [RAM_SEL_W-1:0] bank_data,
    input  logic                 src_cmd,
    input  logic                 io_cmd,
    input  logic                 stall,
    output logic [CYC_W-1:0]     cycle,
    output logic                 sync,
    output logic [3:0]           inst_opr,
    output logic [3:0]           inst_opa,
    output logic                 inst_valid,
    output logic [ROM_BANKS-1:0] rom_cmd,
    output logic [RAM_BANKS-1:0] ram_cmd
);

    localparam logic [CYC_W-1:0] CYC_A_LAST = CYC_W'(ADDR_NIBBLES - 1);
    localparam logic [CYC_W-1:0] CYC_M1     = CYC_W'(ADDR_NIBBLES);
    localparam logic [CYC_W-1:0] CYC_M2     = CYC_W'(ADDR_NIBBLES + 1);
    localparam logic [CYC_W-1:0] CYC_X1     = CYC_W'(ADDR_NIBBLES + 2);
    localparam logic [CYC_W-1:0] CYC_X2     = CYC_W'(ADDR_NIBBLES + 3);
    localparam logic [CYC_W-1:0] CYC_X3     = CYC_W'(ADDR_NIBBLES + 4);

    logic [CYC_W-1:0]     cycle_q, cycle_d;
    logic                 run_q;
    logic [ROM_SEL_W-1:0] rom_bank_q, rom_bank_d;
    logic [RAM_SEL_W-1:0] ram_bank_q, ram_bank_d;
    logic [3:0]           data_out_q, data_out_d;
    logic                 data_oe_q, data_oe_d;
    logic                 sync_q, sync_d;
    logic [3:0]           inst_opr_q, inst_opr_d;
    logic [3:0]           inst_opa_q, inst_opa_d;
    logic                 inst_valid_q, inst_valid_d;
    logic [ROM_BANKS-1:0] rom_cmd_q, rom_cmd_d;
    logic [RAM_BANKS-1:0] ram_cmd_q, ram_cmd_d;

    logic                 stall_hold_s;
    logic                 rom_sel_ok_s;
    logic                 ram_sel_ok_s;
    logic                 rom_fire_s;
    logic                 ram_fire_s;
    logic [ROM_BANKS-1:0] rom_mask_s;
    logic [RAM_BANKS-1:0] ram_mask_s;
    logic [3:0]           addr_nibble_s;

`ifdef BUS_STALL_EN
    assign stall_hold_s = run_q && (cycle_q == CYC_X3) && stall;
`else
    logic unused_stall_s;
    assign unused_stall_s = stall;
    assign stall_hold_s   = 1'b0;
`endif

    assign rom_sel_ok_s = (32'(rom_bank_sel) < ROM_BANKS);
    assign ram_sel_ok_s = (32'(bank_data) < RAM_BANKS);

    // Subcycle advance; the first clock out of reset enters A1 rather than skipping it.
    always_comb begin
        cycle_d = cycle_q;
        if (!run_q) begin
            cycle_d = '0;
        end else if (stall_hold_s) begin
            cycle_d = cycle_q;
        end else if (cycle_q >= CYC_X3) begin
            cycle_d = '0;
        end else begin
            cycle_d = cycle_q + CYC_W'(1'b1);
        end
    end

    // Bank registers; out-of-range selections leave the old bank in place.
    always_comb begin
        rom_bank_d = rom_bank_q;
        ram_bank_d = ram_bank_q;
        if (run_q && (cycle_q == CYC_X3) && rom_sel_ok_s) begin
            rom_bank_d = rom_bank_sel;
        end else begin
            rom_bank_d = rom_bank_q;
        end
        if (bank_write && ram_sel_ok_s) begin
            ram_bank_d = bank_data;
        end else begin
            ram_bank_d = ram_bank_q;
        end
    end

    // Select the pc nibble for the address subcycle being entered.
    always_comb begin
        addr_nibble_s = 4'h0;
        for (int k = 0; k < ADDR_NIBBLES; k++) begin
            addr_nibble_s = (cycle_d == CYC_W'(k)) ? pc[4*k +: 4] : addr_nibble_s;
        end
    end

    // Strobes use the freshly loaded ROM bank but the RAM bank from before any same-clock write.
    assign rom_fire_s = (cycle_d == CYC_A_LAST) || ((cycle_d == CYC_M2) && io_cmd);
    assign ram_fire_s = ((cycle_d == CYC_X2) && src_cmd) || ((cycle_d == CYC_M2) && io_cmd);
    assign rom_mask_s = ROM_BANKS'(1'b1) << rom_bank_d;
    assign ram_mask_s = RAM_BANKS'(1'b1) << ram_bank_q;

    // Next values of the registered bus outputs for the subcycle being entered.
    always_comb begin
        data_out_d   = 4'h0;
        data_oe_d    = 1'b0;
        rom_cmd_d    = {ROM_BANKS{1'b1}};
        ram_cmd_d    = {RAM_BANKS{1'b1}};
        sync_d       = (cycle_d == CYC_X3);
        inst_valid_d = (cycle_d == CYC_X1);
        if (reg_out_enable) begin
            data_out_d = regval;
            data_oe_d  = 1'b1;
        end else if (cycle_d < CYC_M1) begin
            data_out_d = addr_nibble_s;
            data_oe_d  = 1'b1;
        end else begin
            data_out_d = 4'h0;
            data_oe_d  = 1'b0;
        end
        if (rom_fire_s) begin
            rom_cmd_d = ~rom_mask_s;
        end else begin
            rom_cmd_d = {ROM_BANKS{1'b1}};
        end
        if (ram_fire_s) begin
            ram_cmd_d = ~ram_mask_s;
        end else begin
            ram_cmd_d = {RAM_BANKS{1'b1}};
        end
    end

    // Opcode nibbles are taken from the pins at the close of M1 and M2.
    always_comb begin
        inst_opr_d = inst_opr_q;
        inst_opa_d = inst_opa_q;
        if (run_q && (cycle_q == CYC_M1)) begin
            inst_opr_d = data_in;
        end else begin
            inst_opr_d = inst_opr_q;
        end
        if (run_q && (cycle_q == CYC_M2)) begin
            inst_opa_d = data_in;
        end else begin
            inst_opa_d = inst_opa_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            cycle_q      <= '0;
            run_q        <= 1'b0;
            rom_bank_q   <= '0;
            ram_bank_q   <= '0;
            data_out_q   <= 4'h0;
            data_oe_q    <= 1'b0;
            sync_q       <= 1'b0;
            inst_opr_q   <= 4'h0;
            inst_opa_q   <= 4'h0;
            inst_valid_q <= 1'b0;
            rom_cmd_q    <= {ROM_BANKS{1'b1}};
            ram_cmd_q    <= {RAM_BANKS{1'b1}};
        end else begin
            cycle_q      <= cycle_d;
            run_q        <= 1'b1;
            rom_bank_q   <= rom_bank_d;
            ram_bank_q   <= ram_bank_d;
            data_out_q   <= data_out_d;
            data_oe_q    <= data_oe_d;
            sync_q       <= sync_d;
            inst_opr_q   <= inst_opr_d;
            inst_opa_q   <= inst_opa_d;
            inst_valid_q <= inst_valid_d;
            rom_cmd_q    <= rom_cmd_d;
            ram_cmd_q    <= ram_cmd_d;
        end
    end

    assign cycle      = cycle_q;
    assign sync       = sync_q;
    assign data_out   = data_out_q;
    assign data_oe    = data_oe_q;
    assign inst_opr   = inst_opr_q;
    assign inst_opa   = inst_opa_q;
    assign inst_valid = inst_valid_q;
    assign rom_cmd    = rom_cmd_q;
    assign ram_cmd    = ram_cmd_q;

endmodule
